data_mem_arbiter: RTL and testbench

//  Shares the single-port DataMemory between the single-cycle CPU (lw/sw) and a

---
 rtl/data_mem_arbiter_if.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// CPU / debug / RAM bus bundle for data_mem_arbiter.
// The arbiter uses the slave modport. The CPU datapath, debug port and RAM model use master.
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_re;
    logic                  cpu_we;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [DATA_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_ack;

    logic [DATA_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output ram_addr, ram_wdata, ram_we, ram_re,
        input  ram_rdata
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  ram_addr, ram_wdata, ram_we, ram_re,
        output ram_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Single-port DataMemory arbiter: CPU lw/sw vs debug/loader port, round robin on contention.
// Define MMIO_PORT_EN to decode the PortIn/PortOut registers instead of passing them to RAM.
module data_mem_arbiter #(
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] PORT_OUT_ADDR = 32'h1001_0024,
    parameter logic [DATA_WIDTH-1:0] PORT_IN_ADDR  = 32'h1001_0028
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_arbiter_if.slave     bus,
    input  logic [7:0]            port_in,
    output logic [DATA_WIDTH-1:0] port_out
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t                state_q, state_d;
    logic                  last_dbg_q, last_dbg_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

    logic                  cpu_req, dbg_elig, dbg_gnt, cpu_gnt;
    logic [DATA_WIDTH-1:0] sel_addr, sel_wdata, rd_mux;
    logic                  sel_we, sel_re, hit_in, hit_out;
    logic [7:0]            port_in_val;

`ifdef MMIO_PORT_EN
    logic [7:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DATA_WIDTH-1:0] port_out_q, port_out_d;

    always_comb begin
        sync1_d    = port_in;
        sync2_d    = sync1_q;
        port_out_d = port_out_q;
        if (sel_we && hit_out && !reset)
            port_out_d = sel_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            port_out_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            port_out_q <= port_out_d;
        end
    end

    assign hit_in      = (sel_addr == PORT_IN_ADDR);
    assign hit_out     = (sel_addr == PORT_OUT_ADDR);
    assign port_in_val = sync2_q;
    assign port_out    = port_out_q;
`else
    logic unused_mmio;
    assign unused_mmio = ^{port_in, PORT_IN_ADDR, PORT_OUT_ADDR};
    assign hit_in      = 1'b0;
    assign hit_out     = 1'b0;
    assign port_in_val = '0;
    assign port_out    = '0;
`endif

    always_comb begin
        cpu_req  = bus.cpu_re | bus.cpu_we;
        // Debug is held off while its ack is in flight and while reset is high.
        dbg_elig = bus.dbg_req && (state_q == IDLE) && !reset;
        dbg_gnt  = dbg_elig && (!cpu_req || !last_dbg_q);
        cpu_gnt  = cpu_req && !dbg_gnt;

        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_re    = 1'b0;
        if (dbg_gnt) begin
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
            sel_we    = bus.dbg_we;
            sel_re    = !bus.dbg_we;
        end else if (cpu_gnt) begin
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
            sel_we    = bus.cpu_we;
            sel_re    = bus.cpu_re;
        end

        rd_mux = hit_in ? {{(DATA_WIDTH-8){1'b0}}, port_in_val} : bus.ram_rdata;

        last_dbg_d = last_dbg_q;
        if (cpu_req && dbg_elig)
            last_dbg_d = dbg_gnt;

        dbg_rdata_d = dbg_rdata_q;
        if (dbg_gnt && !bus.dbg_we)
            dbg_rdata_d = rd_mux;

        state_d = IDLE;
        if (state_q == IDLE && dbg_gnt)
            state_d = ACK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_dbg_q  <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dbg_q  <= last_dbg_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.ram_addr  = sel_addr;
    assign bus.ram_wdata = sel_wdata;
    assign bus.ram_we    = sel_we && !hit_out && !reset;
    assign bus.ram_re    = sel_re && !hit_in;
    assign bus.cpu_rdata = rd_mux;
    assign bus.cpu_stall = cpu_req && dbg_gnt;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.dbg_ack   = (state_q == ACK);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_in;
    logic [31:0] port_out;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

    data_mem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .port_in (port_in),
        .port_out(port_out)
    );

    // RAM model: combinational read, write on the rising edge.
    logic [31:0] tb_ram [16];
    logic        ram_init;
    logic        ram_override;
    logic [31:0] ram_force_val;

    assign bus.ram_rdata = ram_override ? ram_force_val : tb_ram[bus.ram_addr[5:2]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) tb_ram[i] <= 32'hA000_0000 ^ (i * 32'h0101_0101);
        end else if (bus.ram_we) begin
            tb_ram[bus.ram_addr[5:2]] <= bus.ram_wdata;
        end
    end

    typedef struct {
        logic        cre, cwe;
        logic [31:0] caddr, cwdata;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata, rram;
        logic [31:0] e_crdata, e_raddr, e_rwdata;
        logic        e_stall, e_we, e_re;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] ref_mem [16];
    logic        m_last_dbg, m_ack, m_dwin, m_cwin, m_elig, m_creq;
    logic [31:0] m_dbg_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_re    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset    = 1'b1;
        ram_init = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        ram_init = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA000_0000 ^ (i * 32'h0101_0101);
    endtask

    initial begin
        port_in       = 8'h00;
        ram_override  = 1'b0;
        ram_force_val = '0;
        ram_init      = 1'b0;
        idle_inputs();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_dbg_ack", {31'b0, bus.dbg_ack}, 0);
        chk("rst_dbg_rdata", bus.dbg_rdata, 0);
        chk("rst_port_out", port_out, 0);
        chk("rst_cpu_stall", {31'b0, bus.cpu_stall}, 0);
        chk("rst_ram_we", {31'b0, bus.ram_we}, 0);
        do_reset();

        // {cre,cwe,caddr,cwdata,dreq,dwe,daddr,dwdata,rram, e_crdata,e_raddr,e_rwdata,e_stall,e_we,e_re}
        vecs[0] = '{1,0,32'h1001_0004,32'h0,0,0,0,0,32'hDEAD_BEEF, 32'hDEAD_BEEF,32'h1001_0004,32'h0,0,0,1};
        vecs[1] = '{0,1,32'h1001_0010,32'hCAFE_0001,0,0,0,0,32'h1111_1111, 32'h1111_1111,32'h1001_0010,32'hCAFE_0001,0,1,0};
        vecs[2] = '{0,0,32'h1001_0014,32'h5,0,0,0,0,32'h2222_2222, 32'h2222_2222,32'h0,32'h0,0,0,0};
        vecs[3] = '{0,0,0,0,1,0,32'h1001_0008,32'h0,32'h3333_3333, 32'h3333_3333,32'h1001_0008,32'h0,0,0,1};
        vecs[4] = '{0,0,0,0,1,1,32'h1001_0008,32'h1234,32'h4444_4444, 32'h4444_4444,32'h1001_0008,32'h1234,0,1,0};
        // First contention after reset goes to debug, the next one to the CPU.
        vecs[5] = '{1,0,32'h1001_0000,32'h0,1,1,32'h1001_000C,32'hBEEF,32'h5555_5555, 32'h5555_5555,32'h1001_000C,32'hBEEF,1,1,0};
        vecs[6] = '{0,1,32'h1001_0018,32'h7777,1,0,32'h1001_001C,32'h0,32'h6666_6666, 32'h6666_6666,32'h1001_0018,32'h7777,0,1,0};

        ram_override = 1'b1;
        for (int v = 0; v < 7; v++) begin
            bus.cpu_re    = vecs[v].cre;
            bus.cpu_we    = vecs[v].cwe;
            bus.cpu_addr  = vecs[v].caddr;
            bus.cpu_wdata = vecs[v].cwdata;
            bus.dbg_req   = vecs[v].dreq;
            bus.dbg_we    = vecs[v].dwe;
            bus.dbg_addr  = vecs[v].daddr;
            bus.dbg_wdata = vecs[v].dwdata;
            ram_force_val = vecs[v].rram;
            @(negedge clk);
            chk($sformatf("vec%0d_cpu_rdata", v), bus.cpu_rdata, vecs[v].e_crdata);
            chk($sformatf("vec%0d_cpu_stall", v), {31'b0, bus.cpu_stall}, {31'b0, vecs[v].e_stall});
            chk($sformatf("vec%0d_ram_addr", v), bus.ram_addr, vecs[v].e_raddr);
            chk($sformatf("vec%0d_ram_wdata", v), bus.ram_wdata, vecs[v].e_rwdata);
            chk($sformatf("vec%0d_ram_we", v), {31'b0, bus.ram_we}, {31'b0, vecs[v].e_we});
            chk($sformatf("vec%0d_ram_re", v), {31'b0, bus.ram_re}, {31'b0, vecs[v].e_re});
            tick();
            idle_inputs();
            tick();
        end
        ram_override = 1'b0;

        // Debug write with CPU idle: one RAM write, ack next cycle, no re-issue during ack.
        do_reset();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h1001_0008; bus.dbg_wdata = 32'h1234;
        @(negedge clk);
        chk("dw_grant_we", {31'b0, bus.ram_we}, 1);
        chk("dw_grant_ack", {31'b0, bus.dbg_ack}, 0);
        tick();
        @(negedge clk);
        chk("dw_ack", {31'b0, bus.dbg_ack}, 1);
        chk("dw_ack_no_we", {31'b0, bus.ram_we}, 0);
        chk("dw_rdata_kept", bus.dbg_rdata, 0);
        tick();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        chk("dw_ack_pulse", {31'b0, bus.dbg_ack}, 0);
        tick();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0;
        tick();
        @(negedge clk);
        chk("dr_ack", {31'b0, bus.dbg_ack}, 1);
        chk("dr_rdata", bus.dbg_rdata, 32'h1234);
        tick();
        bus.dbg_req = 1'b0;

        // Strict alternation over 6 contested cycles: CPU sw held, debug read re-requested.
        do_reset();
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1001_0004; bus.cpu_wdata = 32'h99;
        bus.dbg_we = 1'b0; bus.dbg_addr = 32'h1001_0008;
        for (int k = 0; k < 6; k++) begin
            bus.dbg_req = 1'b1;
            @(negedge clk);
            chk($sformatf("alt%0d_stall", k), {31'b0, bus.cpu_stall}, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("alt%0d_ram_we", k), {31'b0, bus.ram_we}, (k % 2 == 0) ? 0 : 1);
            tick();
            if (k % 2 == 0) begin
                @(negedge clk);
                chk($sformatf("alt%0d_ack", k), {31'b0, bus.dbg_ack}, 1);
                tick();
                bus.dbg_req = 1'b0;
                tick();
            end
        end
        idle_inputs();

        // Reset in the grant cycle of a debug write.
        tick();
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h1001_0000;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h1001_0030; bus.dbg_wdata = 32'h77;
        reset = 1'b1;
        @(negedge clk);
        chk("rg_ram_we", {31'b0, bus.ram_we}, 0);
        chk("rg_stall", {31'b0, bus.cpu_stall}, 0);
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rg_ack", {31'b0, bus.dbg_ack}, 0);
        chk("rg_port_out", port_out, 0);
        tick();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h1001_0030;
        @(negedge clk);
        chk("rg_idle_grant", {31'b0, bus.ram_re}, 1);
        tick();
        @(negedge clk);
        chk("rg_mem_kept", bus.dbg_rdata, 32'hA000_0000 ^ (12 * 32'h0101_0101));
        tick();
        idle_inputs();

`ifdef MMIO_PORT_EN
        do_reset();
        port_in = 8'hA5;
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1001_0024; bus.cpu_wdata = 32'h55;
        @(negedge clk);
        chk("mmio_out_no_we", {31'b0, bus.ram_we}, 0);
        tick();
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b1; bus.cpu_addr = 32'h1001_0028;
        @(negedge clk);
        chk("mmio_port_out", port_out, 32'h55);
        chk("mmio_in_lat", bus.cpu_rdata, 32'h0);
        tick();
        @(negedge clk);
        chk("mmio_in", bus.cpu_rdata, 32'h0000_00A5);
        chk("mmio_in_no_re", {31'b0, bus.ram_re}, 0);
        tick();
        idle_inputs();
        port_in = 8'h00;
`else
        do_reset();
        port_in = 8'hA5;
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1001_0024; bus.cpu_wdata = 32'h55;
        @(negedge clk);
        chk("nommio_we", {31'b0, bus.ram_we}, 1);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("nommio_port_out", port_out, 0);
        port_in = 8'h00;
`endif

        // Randomized run against a transaction-level model with its own memory image.
        do_reset();
        m_last_dbg  = 1'b0;
        m_ack       = 1'b0;
        m_dbg_rdata = '0;
        for (int c = 0; c < 600; c++) begin
            if (m_ack) bus.dbg_req = 1'b0;
            else if (!bus.dbg_req && ($urandom % 3 == 0)) begin
                bus.dbg_req   = 1'b1;
                bus.dbg_we    = $urandom % 2 == 0;
                bus.dbg_addr  = 32'h1001_0000 + 4 * $urandom_range(0, 7);
                bus.dbg_wdata = $urandom;
            end
            case ($urandom % 4)
                1, 3:    begin bus.cpu_re = 1'b1; bus.cpu_we = 1'b0; end
                2:       begin bus.cpu_re = 1'b0; bus.cpu_we = 1'b1; end
                default: begin bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; end
            endcase
            bus.cpu_addr  = 32'h1001_0000 + 4 * $urandom_range(0, 7);
            bus.cpu_wdata = $urandom;
            @(negedge clk);
            m_creq = bus.cpu_re | bus.cpu_we;
            m_elig = bus.dbg_req && !m_ack;
            m_dwin = m_elig && (!m_creq || !m_last_dbg);
            m_cwin = m_creq && !m_dwin;
            chk("rnd_ack", {31'b0, bus.dbg_ack}, {31'b0, m_ack});
            if (m_ack) chk("rnd_dbg_rdata", bus.dbg_rdata, m_dbg_rdata);
            chk("rnd_stall", {31'b0, bus.cpu_stall}, {31'b0, m_creq && m_dwin});
            chk("rnd_ram_we", {31'b0, bus.ram_we},
                {31'b0, m_dwin ? bus.dbg_we : (m_cwin && bus.cpu_we)});
            chk("rnd_ram_re", {31'b0, bus.ram_re},
                {31'b0, m_dwin ? !bus.dbg_we : (m_cwin && bus.cpu_re)});
            if (m_dwin) chk("rnd_ram_addr", bus.ram_addr, bus.dbg_addr);
            else if (m_cwin) chk("rnd_ram_addr", bus.ram_addr, bus.cpu_addr);
            if (m_cwin && bus.cpu_re) chk("rnd_cpu_rdata", bus.cpu_rdata, ref_mem[bus.cpu_addr[5:2]]);
            if (m_creq && m_elig) m_last_dbg = m_dwin;
            if (m_dwin) begin
                if (bus.dbg_we) ref_mem[bus.dbg_addr[5:2]] = bus.dbg_wdata;
                else            m_dbg_rdata = ref_mem[bus.dbg_addr[5:2]];
            end
            if (m_cwin && bus.cpu_we) ref_mem[bus.cpu_addr[5:2]] = bus.cpu_wdata;
            m_ack = m_dwin;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
